// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller:
// FSM encoding, the opcodes that read rt, and instruction field positions.
package hazard_ctrl_pkg;

    // Controller state. RUN is the normal flowing pipeline.
    // STALL holds the extra bubble cycles of a multi-cycle load-use stall.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } hz_state_e;

    // Opcodes whose rt field is a source operand, not a destination.
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // Instruction field slice positions.
    localparam int OP_MSB = 31;
    localparam int OP_LSB = 26;
    localparam int RS_MSB = 25;
    localparam int RS_LSB = 21;
    localparam int RT_MSB = 20;
    localparam int RT_LSB = 16;

    // The stall-cycle counter only needs to hold LOAD_STALL_CYCLES-1, which is at most 14.
    localparam int STALL_CNT_W = 4;

    function automatic logic [5:0] op_of(input logic [31:0] ins);
        return ins[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [4:0] rs_of(input logic [31:0] ins);
        return ins[RS_MSB:RS_LSB];
    endfunction

    function automatic logic [4:0] rt_of(input logic [31:0] ins);
        return ins[RT_MSB:RT_LSB];
    endfunction

    // True when the opcode uses rt as a source register.
    function automatic logic reads_rt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// The master modport is the pipeline. The slave modport is hazard_ctrl.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             PCSrc;
    logic [31:0]      IF_ID_instruction_i;
    logic [31:0]      IF_ID_instruction_r;
    logic             IF_ID_type_i;
    logic             IF_ID_type_r;
    logic             ID_EX_MemRead_i;
    logic [31:0]      ID_EX_write_register_i;

    logic             hazard;
    logic             PC_write;
    logic             IF_ID_write;
    logic             IF_ID_flush;
    logic             stall_active;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output PCSrc, IF_ID_instruction_i, IF_ID_instruction_r,
               IF_ID_type_i, IF_ID_type_r, ID_EX_MemRead_i, ID_EX_write_register_i,
        input  hazard, PC_write, IF_ID_write, IF_ID_flush, stall_active,
               stall_count, flush_count
    );

    modport slave (
        input  PCSrc, IF_ID_instruction_i, IF_ID_instruction_r,
               IF_ID_type_i, IF_ID_type_r, ID_EX_MemRead_i, ID_EX_write_register_i,
        output hazard, PC_write, IF_ID_write, IF_ID_flush, stall_active,
               stall_count, flush_count
    );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with an async active-low clear. Used for the debug event counters.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_en,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next value: step by one unless already pinned at all-ones.
    always_comb begin
        count_d = count_q;
        if (inc_en && (count_q != {W{1'b1}}))
            count_d = count_q + W'(1);
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;
endmodule

// File: rtl/hazard_ctrl.sv
// Load-use hazard and redirect-flush controller for the dual-issue pipeline.
// Detection and output decode are combinational (Mealy), so the first bubble
// lands in the same cycle as the dependency. A multi-cycle stall is finished
// by the STALL state, which counts down the remaining bubbles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic          clk,
    input  logic          btnc_i,
    hazard_ctrl_if.slave  hz
);
    localparam logic [STALL_CNT_W-1:0] STALL_RELOAD = STALL_CNT_W'(LOAD_STALL_CYCLES - 1);

    hz_state_e              state_q, state_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0] dst;
    logic [4:0] rs_i, rt_i, rs_r, rt_r;
    logic       hit_i, hit_r, luse;

    logic hazard_c, pc_write_c, if_id_write_c, if_id_flush_c, stall_active_c;
    logic stall_inc, flush_inc;

    // Only the low five bits of the write register and the op/rs/rt fields of
    // the instructions are used. The rest of each input is left unused on purpose.
    logic unused_bits;
    assign unused_bits = ^{hz.ID_EX_write_register_i[31:5],
                           hz.IF_ID_instruction_i[15:0],
                           hz.IF_ID_instruction_r[31:26],
                           hz.IF_ID_instruction_r[15:0]};

    // Source-register extraction and load-use match against the EX i-slot load.
    always_comb begin
        dst   = hz.ID_EX_write_register_i[4:0];
        rs_i  = rs_of(hz.IF_ID_instruction_i);
        rt_i  = rt_of(hz.IF_ID_instruction_i);
        rs_r  = rs_of(hz.IF_ID_instruction_r);
        rt_r  = rt_of(hz.IF_ID_instruction_r);
        // i-slot rt is a destination for loads/immediates, so compare it only for rt readers.
        hit_i = hz.IF_ID_type_i &&
                ((rs_i == dst) || (reads_rt(op_of(hz.IF_ID_instruction_i)) && (rt_i == dst)));
        // The r-slot always reads both rs and rt.
        hit_r = hz.IF_ID_type_r && ((rs_r == dst) || (rt_r == dst));
        luse  = hz.ID_EX_MemRead_i && (dst != 5'd0) && (hit_i || hit_r);
    end

    // FSM next-state and Mealy output decode. A redirect always wins.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        hazard_c       = 1'b0;
        pc_write_c     = 1'b1;
        if_id_write_c  = 1'b1;
        if_id_flush_c  = 1'b0;
        stall_active_c = 1'b0;
        stall_inc      = 1'b0;
        flush_inc      = 1'b0;

        if (hz.PCSrc) begin
            // Redirect: flush IF/ID and keep fetching. Any pending stall is dropped.
            if_id_flush_c = 1'b1;
            flush_inc     = 1'b1;
            state_d       = ST_RUN;
            cnt_d         = '0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (luse) begin
                        hazard_c      = 1'b1;
                        pc_write_c    = 1'b0;
                        if_id_write_c = 1'b0;
                        stall_inc     = 1'b1;
                        if (LOAD_STALL_CYCLES > 1) begin
                            cnt_d   = STALL_RELOAD;
                            state_d = ST_STALL;
                        end
                    end
                end
                ST_STALL: begin
                    // ID/EX holds bubbles here, so luse is not looked at.
                    hazard_c       = 1'b1;
                    pc_write_c     = 1'b0;
                    if_id_write_c  = 1'b0;
                    stall_active_c = 1'b1;
                    cnt_d          = cnt_q - STALL_CNT_W'(1);
                    if (cnt_q == STALL_CNT_W'(1))
                        state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State and stall-cycle counter registers.
    always_ff @(posedge clk or negedge btnc_i) begin
        if (!btnc_i) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are held low for as long as reset is asserted, including PC/IF_ID enables.
    assign hz.hazard       = btnc_i & hazard_c;
    assign hz.PC_write     = btnc_i & pc_write_c;
    assign hz.IF_ID_write  = btnc_i & if_id_write_c;
    assign hz.IF_ID_flush  = btnc_i & if_id_flush_c;
    assign hz.stall_active = btnc_i & stall_active_c;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .rst_n  (btnc_i),
        .inc_en (stall_inc),
        .count  (hz.stall_count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk    (clk),
        .rst_n  (btnc_i),
        .inc_en (flush_inc),
        .count  (hz.flush_count)
    );
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Hazard and stall controller for the dual-issue pipeline, the producer of the `hazard` stall/flush input that the ID/EX pipeline register consumes. It detects load-use dependencies between a load in the EX stage (i-slot) and either instruction in IF/ID. It freezes PC and IF/ID for a programmable number of cycles and injects bubbles into ID/EX. It also handles redirect flushes and keeps saturating stall and flush event counters for on-board debug.

## Interface
- `LOAD_STALL_CYCLES`, default 1: bubbles inserted per load-use event; legal range 1–15.
- `CNT_W`, default 16: width of each event counter.

Ports:
- `clk`  in  1  pipeline clock.
- `btnc_i`  in  1  reset; asynchronous, active-low.
- `PCSrc`  in  1  branch taken / redirect, resolved in EX.
- `IF_ID_instruction_i`  in  32  i-slot instruction in ID.
- `IF_ID_instruction_r`  in  32  r-slot instruction in ID.
- `IF_ID_type_i`  in  1  i-slot valid.
- `IF_ID_type_r`  in  1  r-slot valid.
- `ID_EX_MemRead_i`  in  1  load in EX i-slot.
- `ID_EX_write_register_i`  in  32  destination of the EX i-slot; only bits [4:0] are used.
- `hazard`  out  1  squash the ID/EX load (bubble).
- `PC_write`  out  1  PC update enable.
- `IF_ID_write`  out  1  IF/ID load enable.
- `IF_ID_flush`  out  1  clear IF/ID to zero.
- `stall_active`  out  1  FSM is in STALL.
- `stall_count`  out  `CNT_W`  load-use events seen, saturating.
- `flush_count`  out  `CNT_W`  redirects seen, saturating.

## Operation
Source register extraction:
- rs = [25:21], always compared.
- rt = [20:16], compared for the r-slot always.
- rt is compared for the i-slot only when opcode [31:26] is 0x00, 0x04, 0x05 or 0x2B.

Load-use detection (`luse`) is true when all of the following hold:
- `ID_EX_MemRead_i` is 1;
- dst = `ID_EX_write_register_i[4:0]` is not 0;
- dst matches a compared source of a valid slot.

Dependencies inside one IF/ID bundle are not handled. The scheduler guarantees they do not occur.

FSM states:
- **RUN**
  - If `PCSrc`: `IF_ID_flush`=1, `hazard`=0, `PC_write`=1, `IF_ID_write`=1. `flush_count` increments. State stays RUN.
  - Else if `luse`: `hazard`=1, `PC_write`=0, `IF_ID_write`=0. `stall_count` increments. If `LOAD_STALL_CYCLES`>1, load `cnt` = `LOAD_STALL_CYCLES`−1 and go to STALL.
  - Else: `PC_write`=1, `IF_ID_write`=1; `hazard`, `IF_ID_flush` and `stall_active` are 0.
- **STALL**
  - Outputs: `hazard`=1, `PC_write`=0, `IF_ID_write`=0, `stall_active`=1. `luse` is ignored, because ID/EX holds bubbles.
  - Each cycle `cnt` decrements. When `cnt`==1, return to RUN.
  - `PCSrc` in STALL aborts the stall: apply the RUN/`PCSrc` outputs that cycle, increment `flush_count`, clear `cnt`, go to RUN.

Other rules:
- `PCSrc` has priority over `luse` in every state.
- Counters saturate at all-ones and never wrap.

## Timing
- Detection and output decoding are Mealy (combinational from state and inputs). The first bubble is therefore asserted in the same cycle the dependency is present.
- Total stall length is exactly `LOAD_STALL_CYCLES` cycles.
- State, `cnt` and both event counters are updated on the rising edge of `clk`.
- Counters are visible one cycle after the event.
- While `btnc_i`=0, asynchronously:
  - state=RUN, `cnt`=0, `stall_count`=0, `flush_count`=0;
  - outputs forced to `hazard`=0, `IF_ID_flush`=0, `PC_write`=0, `IF_ID_write`=0, `stall_active`=0.
- Reset asserted in the middle of a STALL returns to RUN immediately; no residual stall after release.
- `PCSrc` and `luse` in the same cycle: flush only, `stall_count` unchanged.

## Structure
- Shared pipeline package: state encoding (RUN=0, STALL=1), opcode constants (RTYPE=0x00, BEQ=0x04, BNE=0x05, SW=0x2B), and field slice positions.
- Sub-module `sat_counter` (parameterised width; increment enable; async active-low clear) is instantiated twice.
- Top level holds the detection logic and the FSM.

## Test plan
- Reset: hold `btnc_i`=0 with `PCSrc`=1 → all four control outputs 0, both counters 0. Release → `PC_write`=1, `IF_ID_write`=1.
- i-slot load-use, `LOAD_STALL_CYCLES`=1: EX `lw` writes $8; ID i-slot is `add` with rs=$8 → `hazard`=1 and `PC_write`=0 for exactly one cycle; `stall_count`=1.
- r-slot rt match with `LOAD_STALL_CYCLES`=3: dst=$9, r-slot rt=$9 → `hazard` high for 3 cycles, `stall_active` high in cycles 2–3, then RUN.
- No false stall:
  - dst=$0 with a matching rs → no stall;
  - i-slot `lw` whose rt equals dst → no stall, because rt is not compared for `lw`;
  - invalid slot with a match → no stall.
- Simultaneous events: `PCSrc`=1 together with `luse` → `IF_ID_flush`=1, `hazard`=0, `flush_count`+1, `stall_count` unchanged. `PCSrc` in STALL cycle 2 of 3 → stall aborted, RUN next cycle.
- Saturation: `CNT_W`=4, 20 load-use events → `stall_count`=15.
